// File: rtl/mc_control_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS main control FSM (mc_control):
//   - state encodings (RESET=0 upward, in sequencing order)
//   - instruction opcode / R-type funct constants
//   - ALU opcode constants driven towards the ALU
//   - operand-select and PC-source encodings for the datapath muxes
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_R_EXEC    = 4'd3,
    S_R_WB      = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_JR        = 4'd11,
    S_I_EXEC    = 4'd12,
    S_I_WB      = 4'd13
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU opcodes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG_A = 2'd1;
  localparam logic [1:0] SRCA_REG_B = 2'd2;

  // ALU operand B select
  localparam logic [1:0] SRCB_REG_B   = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG_A  = 2'd3;

endpackage

// File: rtl/mc_control_if.sv
// -----------------------------------------------------------------------------
// mc_control_if
// Bundles the controller's instruction/flag inputs and its datapath control
// outputs.
//   master : the control FSM (consumes opcode/funct/zero_flag/mem_ready,
//            drives ALU opcode, selects, strobes, enables, illegal, state)
//   slave  : the datapath / memory side
// -----------------------------------------------------------------------------
interface mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic [3:0] alu_opcode;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output alu_opcode, alu_src_a, alu_src_b, pc_en, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, state
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  alu_opcode, alu_src_a, alu_src_b, pc_en, pc_source, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           illegal, state
  );
endinterface

// File: rtl/mc_control_alu_decode.sv
// -----------------------------------------------------------------------------
// alu_decode
// Combinational R-type funct decoder.
//   funct  in  6 : IR[5:0]
//   alu_op out 4 : ALU opcode for the funct (add when not recognised)
//   shift  out 1 : funct is sll/srl (operand A comes from reg B)
//   valid  out 1 : funct is one of the ALU R-type operations
// jr is not an ALU operation; the controller recognises it separately.
// -----------------------------------------------------------------------------
module alu_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       shift,
  output logic       valid
);
  always_comb begin
    alu_op = ALU_ADD;
    shift  = 1'b0;
    valid  = 1'b1;
    case (funct)
      FN_ADD: alu_op = ALU_ADD;
      FN_SUB: alu_op = ALU_SUB;
      FN_AND: alu_op = ALU_AND;
      FN_OR:  alu_op = ALU_OR;
      FN_SLT: alu_op = ALU_SLT;
      FN_NOR: alu_op = ALU_NOR;
      FN_SLL: begin alu_op = ALU_SLL; shift = 1'b1; end
      FN_SRL: begin alu_op = ALU_SRL; shift = 1'b1; end
      default: valid = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multicycle MIPS main control FSM. Sequences fetch, decode, execute, memory
// and write-back for one instruction at a time.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (state -> RESET, illegal cleared)
//   bus : mc_control_if.master -- opcode/funct/zero_flag/mem_ready in;
//         alu_opcode, alu_src_a/b, pc_en, pc_source, i_or_d, mem_read,
//         mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal,
//         state out
// Outputs are Moore decodes of the state, except ir_write/pc_en in FETCH
// (follow mem_ready) and pc_en in BRANCH (follows zero_flag).
// Optional feature macro: MC_CTRL_BNE_EN -- when defined, opcode 000101 (bne)
// branches on a clear zero flag; otherwise it is an illegal opcode.
// -----------------------------------------------------------------------------
module mc_control
  import mc_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mc_control_if.master  bus
);
  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       lw_q, lw_d;      // MEM_ADDR: load (1) or store (0)
  logic       bne_q, bne_d;    // BRANCH: invert the zero-flag condition

  logic [3:0] dec_op;
  logic       dec_shift;
  logic       dec_valid;

  logic [3:0] alu_opcode;
  logic [1:0] alu_src_a, alu_src_b, pc_source;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write;

  alu_decode u_alu_decode (
    .funct  (bus.funct),
    .alu_op (dec_op),
    .shift  (dec_shift),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET;
      illegal_q <= 1'b0;
      lw_q      <= 1'b0;
      bne_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      lw_q      <= lw_d;
      bne_q     <= bne_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    lw_d       = lw_q;
    bne_d      = bne_q;
    alu_opcode = 4'b0000;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG_B;
    pc_source  = PCSRC_ALU;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;

    case (state_q)
      S_RESET: state_d = S_FETCH;

      // PC+4 is computed alongside the fetch; PC and IR load together when
      // the memory completes.
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_opcode = ALU_ADD;
        ir_write   = bus.mem_ready;
        pc_en      = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end

      // Branch target (PC + imm<<2) is precomputed into ALUOut here.
      S_DECODE: begin
        alu_src_b  = SRCB_IMM_SL2;
        alu_opcode = ALU_ADD;
        state_d    = S_FETCH;
        case (bus.opcode)
          OP_RTYPE: begin
            if (bus.funct == FN_JR) state_d = S_JR;
            else if (dec_valid)     state_d = S_R_EXEC;
            else                    illegal_d = 1'b1;
          end
          OP_LW:   begin lw_d  = 1'b1; state_d = S_MEM_ADDR; end
          OP_SW:   begin lw_d  = 1'b0; state_d = S_MEM_ADDR; end
          OP_BEQ:  begin bne_d = 1'b0; state_d = S_BRANCH;   end
`ifdef MC_CTRL_BNE_EN
          OP_BNE:  begin bne_d = 1'b1; state_d = S_BRANCH;   end
`endif
          OP_J:    state_d = S_JUMP;
          OP_ADDI: state_d = S_I_EXEC;
          default: illegal_d = 1'b1;
        endcase
      end

      S_R_EXEC: begin
        alu_opcode = dec_op;
        alu_src_a  = dec_shift ? SRCA_REG_B : SRCA_REG_A;
        alu_src_b  = SRCB_REG_B;
        state_d    = S_R_WB;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a  = SRCA_REG_A;
        alu_src_b  = SRCB_IMM;
        alu_opcode = ALU_ADD;
        state_d    = lw_q ? S_MEM_READ : S_MEM_WRITE;
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end

      // The ALU compares rs and rt; ALUOut already holds the target.
      S_BRANCH: begin
        alu_src_a  = SRCA_REG_A;
        alu_src_b  = SRCB_REG_B;
        alu_opcode = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_en      = bne_q ? ~bus.zero_flag : bus.zero_flag;
        state_d    = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end

      S_JR: begin
        pc_source = PCSRC_REG_A;
        pc_en     = 1'b1;
        state_d   = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a  = SRCA_REG_A;
        alu_src_b  = SRCB_IMM;
        alu_opcode = ALU_ADD;
        state_d    = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      default: state_d = S_RESET;
    endcase
  end

  assign bus.alu_opcode = alu_opcode;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.pc_en      = pc_en;
  assign bus.pc_source  = pc_source;
  assign bus.i_or_d     = i_or_d;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.ir_write   = ir_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.reg_write  = reg_write;
  assign bus.illegal    = illegal_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
// Testbench for mc_control. Each instruction is expanded into the list of
// cycles it should take (with wait cycles, branch condition and stray
// flag values chosen at random); every cycle's outputs are compared.
// -----------------------------------------------------------------------------
module tb_mc_control;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_control_if bus_if();

  mc_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  typedef struct {
    string      nm;
    logic       rst_in;
    logic       mr;
    logic       zf;
    logic [5:0] op;
    logic [5:0] fn;
    int         st;        // expected debug state, -1 = not checked
    logic [3:0] aop;
    logic [1:0] sa, sb, ps;
    logic       pc_en, iord, mrd, mwr, irw, rdst, m2r, rw, ill;
  } cyc_t;

  cyc_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic ill_m  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cyc_t blank(input string nm, input int st,
                                 input logic [5:0] op, input logic [5:0] fn);
    cyc_t c;
    c.nm = nm; c.rst_in = 1'b0; c.st = st; c.op = op; c.fn = fn;
    c.mr = 1'($urandom_range(0, 1));
    c.zf = 1'($urandom_range(0, 1));
    c.aop = 4'b0000; c.sa = 2'd0; c.sb = 2'd0; c.ps = 2'd0;
    c.pc_en = 0; c.iord = 0; c.mrd = 0; c.mwr = 0; c.irw = 0;
    c.rdst = 0; c.m2r = 0; c.rw = 0; c.ill = 0;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    c.ill = ill_m;
    q.push_back(c);
  endtask

  // Spec ALU table for R-type functs; returns 1 in bit 4 when funct is an ALU op.
  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 5'b1_0010;
      6'b100010: return 5'b1_0110;
      6'b100100: return 5'b1_0000;
      6'b100101: return 5'b1_0001;
      6'b101010: return 5'b1_0111;
      6'b100111: return 5'b1_1100;
      6'b000000: return 5'b1_0100;
      6'b000010: return 5'b1_0101;
      default:   return 5'b0_0000;
    endcase
  endfunction

  // Expands one instruction into its expected cycles.
  // zf: -1 random, else forced in BRANCH. rst_mid: assert rst on first MEM_READ wait.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn, input int wf,
                     input int wm, input int zf, input bit rst_mid);
    cyc_t c;
    string kind;
    logic [4:0] ra;
    for (int w = 0; w <= wf; w++) begin
      c = blank("fetch", 1, op, fn);
      c.mr = (w == wf); c.mrd = 1; c.sb = 2'd1; c.aop = 4'b0010;
      c.irw = c.mr; c.pc_en = c.mr;
      push(c);
    end
    c = blank("decode", 2, op, fn);
    c.sb = 2'd3; c.aop = 4'b0010;
    push(c);

    ra = r_alu(fn);
    case (op)
      6'b000000: kind = (fn == 6'b001000) ? "jr" : (ra[4] ? "r" : "ill");
      6'b100011: kind = "lw";
      6'b101011: kind = "sw";
      6'b000100: kind = "beq";
`ifdef MC_CTRL_BNE_EN
      6'b000101: kind = "bne";
`endif
      6'b000010: kind = "j";
      6'b001000: kind = "addi";
      default:   kind = "ill";
    endcase

    if (kind == "ill") begin
      ill_m = 1'b1;
    end else if (kind == "r") begin
      c = blank("r_exec", -1, op, fn);
      c.aop = ra[3:0]; c.sa = (fn == 6'b000000 || fn == 6'b000010) ? 2'd2 : 2'd1;
      push(c);
      c = blank("r_wb", -1, op, fn);
      c.rw = 1; c.rdst = 1;
      push(c);
    end else if (kind == "jr" || kind == "j") begin
      c = blank(kind, -1, op, fn);
      c.ps = (kind == "jr") ? 2'd3 : 2'd2; c.pc_en = 1;
      push(c);
    end else if (kind == "lw" || kind == "sw") begin
      c = blank("mem_addr", -1, op, fn);
      c.sa = 2'd1; c.sb = 2'd2; c.aop = 4'b0010;
      push(c);
      for (int w = 0; w <= wm; w++) begin
        c = blank((kind == "lw") ? "mem_read" : "mem_write", -1, op, fn);
        c.mr = (w == wm); c.iord = 1;
        if (kind == "lw") c.mrd = 1; else c.mwr = 1;
        if (rst_mid) begin
          c.mr = 1'b0; c.rst_in = 1'b1;
          push(c);
          ill_m = 1'b0;
          c = blank("reset", 0, op, fn);
          push(c);
          return;
        end
        push(c);
      end
      if (kind == "lw") begin
        c = blank("mem_wb", -1, op, fn);
        c.rw = 1; c.m2r = 1;
        push(c);
      end
    end else if (kind == "beq" || kind == "bne") begin
      c = blank(kind, -1, op, fn);
      if (zf >= 0) c.zf = 1'(zf);
      c.sa = 2'd1; c.aop = 4'b0110; c.ps = 2'd1;
      c.pc_en = (kind == "beq") ? c.zf : ~c.zf;
      push(c);
    end else begin
      c = blank("i_exec", -1, op, fn);
      c.sa = 2'd1; c.sb = 2'd2; c.aop = 4'b0010;
      push(c);
      c = blank("i_wb", -1, op, fn);
      c.rw = 1;
      push(c);
    end
  endtask

  task automatic run_q();
    cyc_t c;
    logic [31:0] obs, exp;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      rst              = c.rst_in;
      bus_if.mem_ready = c.mr;
      bus_if.zero_flag = c.zf;
      bus_if.opcode    = c.op;
      bus_if.funct     = c.fn;
      @(negedge clk);
      obs = {12'd0, bus_if.alu_opcode, bus_if.alu_src_a, bus_if.alu_src_b,
             bus_if.pc_source, bus_if.pc_en, bus_if.i_or_d, bus_if.mem_read,
             bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst,
             bus_if.mem_to_reg, bus_if.reg_write, bus_if.illegal};
      exp = {12'd0, c.aop, c.sa, c.sb, c.ps, c.pc_en, c.iord, c.mrd, c.mwr,
             c.irw, c.rdst, c.m2r, c.rw, c.ill};
      check_eq(c.nm, obs, exp);
      if (c.st >= 0) check_eq({c.nm, "_state"}, 32'(bus_if.state), 32'(c.st));
    end
  endtask

  localparam logic [5:0] ops_tab [8] = '{6'b000000, 6'b100011, 6'b101011,
    6'b000100, 6'b000101, 6'b000010, 6'b001000, 6'b111111};
  localparam logic [5:0] fns_tab [10] = '{6'b100000, 6'b100010, 6'b100100,
    6'b100101, 6'b101010, 6'b100111, 6'b000000, 6'b000010, 6'b001000, 6'b000001};

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1;
    bus_if.mem_ready = 1'b0; bus_if.zero_flag = 1'b1;
    bus_if.opcode = 6'b000000; bus_if.funct = 6'b000000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             {bus_if.alu_opcode, bus_if.alu_src_a, bus_if.alu_src_b,
              bus_if.pc_source, bus_if.pc_en, bus_if.i_or_d, bus_if.mem_read,
              bus_if.mem_write, bus_if.ir_write, bus_if.reg_dst,
              bus_if.mem_to_reg, bus_if.reg_write, bus_if.illegal}, 32'd0);
    check_eq("reset_state", 32'(bus_if.state), 32'd0);
    push(blank("reset", 0, 6'd0, 6'd0));
    run_q();

    gen(6'b000000, 6'b100010, 0, 0, -1, 0);  run_q();   // sub
    gen(6'b100011, 6'b000000, 0, 2, -1, 0);  run_q();   // lw, 2 waits
    gen(6'b000100, 6'b000000, 0, 0,  1, 0);  run_q();   // beq taken
    gen(6'b000100, 6'b000000, 0, 0,  0, 0);  run_q();   // beq not taken
    gen(6'b000000, 6'b000000, 1, 0, -1, 0);  run_q();   // sll, fetch wait
    gen(6'b000000, 6'b001000, 0, 0, -1, 0);  run_q();   // jr
    gen(6'b101011, 6'b000000, 2, 1, -1, 0);  run_q();   // sw with waits
    gen(6'b000101, 6'b000000, 0, 0,  1, 0);  run_q();   // bne / illegal
    gen(6'b000101, 6'b000000, 0, 0,  0, 0);  run_q();
    gen(6'b000000, 6'b000001, 0, 0, -1, 0);  run_q();   // illegal funct
    gen(6'b001000, 6'b000000, 0, 0, -1, 0);  run_q();   // addi, illegal sticky
    gen(6'b100011, 6'b000000, 0, 2, -1, 1);  run_q();   // reset mid-stall

    for (int i = 0; i < 400; i++) begin
      op = ops_tab[$urandom_range(0, 7)];
      fn = fns_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      if ($urandom_range(0, 9) == 0) fn = 6'($urandom);
      gen(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), -1,
          ($urandom_range(0, 29) == 0));
      run_q();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
